// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU for its adds.
// While o_alu_own is high the top level routes o_alu_* into the ALU.
module alu_mul_sequencer #(
    parameter int                      WIDTH        = 8,
    parameter int                      ALU_OP_WIDTH = 4,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_ADD      = ALU_OP_WIDTH'(1),
    parameter logic [ALU_OP_WIDTH-1:0] ALU_CHK      = ALU_OP_WIDTH'(9)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    i_start,
    input  logic [WIDTH-1:0]        i_multiplicand,
    input  logic [WIDTH-1:0]        i_multiplier,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [WIDTH-1:0]        o_product_hi,
    output logic [WIDTH-1:0]        o_product_lo,
    output logic                    o_alu_own,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic [WIDTH-1:0]        o_alu_a,
    output logic [WIDTH-1:0]        o_alu_t,
    output logic                    o_alu_latch_flags,
    input  logic [WIDTH-1:0]        i_alu_data,
    input  logic                    i_alu_carry
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_FLAGS
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] sum;
    logic [CW-1:0]    count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            hi           <= '0;
            lo           <= '0;
            m            <= '0;
            sum          <= '0;
            count        <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_product_hi <= '0;
            o_product_lo <= '0;
        end else if (clk_en) begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        hi     <= '0;
                        lo     <= i_multiplier;
                        m      <= i_multiplicand;
                        count  <= '0;
                        o_busy <= 1'b1;
                        state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum   <= i_alu_data;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Carry was latched by the ALU on the ADD edge.
                    {hi, lo} <= {i_alu_carry, sum, lo[WIDTH-1:1]};
                    if (count == CW'(WIDTH - 1)) begin
                        state <= S_FLAGS;
                    end else begin
                        count <= count + CW'(1);
                        state <= S_ADD;
                    end
                end
                S_FLAGS: begin
                    o_product_hi <= hi;
                    o_product_lo <= lo;
                    o_done       <= 1'b1;
                    o_busy       <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_alu_own = o_busy;

    // FLAGS runs a CHK on LO so the ALU flags end up describing the low half.
    always_comb begin
        o_alu_op          = ALU_CHK;
        o_alu_a           = '0;
        o_alu_t           = '0;
        o_alu_latch_flags = 1'b0;
        case (state)
            S_ADD: begin
                o_alu_op          = ALU_ADD;
                o_alu_a           = hi;
                o_alu_t           = lo[0] ? m : '0;
                o_alu_latch_flags = 1'b1;
            end
            S_FLAGS: begin
                o_alu_a           = lo;
                o_alu_latch_flags = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a small ALU model and randomized clk_en.
module tb_alu_mul_sequencer;

    localparam int         W     = 8;
    localparam int         OPW   = 4;
    localparam logic [3:0] A_ADD = 4'd1;
    localparam logic [3:0] A_CHK = 4'd9;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clk_en = 1'b1;
    logic           i_start = 1'b0;
    logic [W-1:0]   i_multiplicand = '0;
    logic [W-1:0]   i_multiplier = '0;
    logic           o_busy, o_done, o_alu_own, o_alu_latch_flags;
    logic [W-1:0]   o_product_hi, o_product_lo, o_alu_a, o_alu_t;
    logic [OPW-1:0] o_alu_op;
    logic [W-1:0]   i_alu_data;
    logic           i_alu_carry;

    alu_mul_sequencer #(
        .WIDTH(W), .ALU_OP_WIDTH(OPW), .ALU_ADD(A_ADD), .ALU_CHK(A_CHK)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_start(i_start),
        .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier),
        .o_busy(o_busy), .o_done(o_done),
        .o_product_hi(o_product_hi), .o_product_lo(o_product_lo),
        .o_alu_own(o_alu_own), .o_alu_op(o_alu_op), .o_alu_a(o_alu_a),
        .o_alu_t(o_alu_t), .o_alu_latch_flags(o_alu_latch_flags),
        .i_alu_data(i_alu_data), .i_alu_carry(i_alu_carry)
    );

    always #5 clk = ~clk;

    // Shared ALU: combinational result, flags latched on enabled edges when requested.
    logic [W:0] alu_sum;
    logic       f_zero = 1'b0, f_odd = 1'b0, f_carry = 1'b0;
    assign alu_sum     = {1'b0, o_alu_a} + {1'b0, o_alu_t};
    assign i_alu_data  = (o_alu_op == A_ADD) ? alu_sum[W-1:0] : o_alu_a;
    assign i_alu_carry = f_carry;

    always @(posedge clk) begin
        if (clk_en && o_alu_latch_flags) begin
            if (o_alu_op == A_ADD) begin
                f_carry <= alu_sum[W];
                f_zero  <= (alu_sum[W-1:0] == '0);
                f_odd   <= alu_sum[0];
            end else begin
                f_carry <= 1'b0;
                f_zero  <= (o_alu_a == '0);
                f_odd   <= o_alu_a[0];
            end
        end
    end

    logic en_rand = 1'b0;
    always @(posedge clk) begin
        #2;
        clk_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int en_cnt = 0;
    always @(posedge clk) if (clk_en && !rst) en_cnt <= en_cnt + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             start_cnt;
    } exp_t;
    exp_t sb[$];

    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] last_prod = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each rising o_done, checks holds otherwise.
    logic        prev_done = 1'b0;
    logic        snap_vld = 1'b0, snap_en = 1'b1, snap_rst = 1'b1;
    logic [63:0] snap = '0, cur;
    initial begin
        forever begin
            @(negedge clk);
            cur = {25'd0, o_busy, o_done, o_product_hi, o_product_lo, o_alu_op,
                   o_alu_a, o_alu_t, o_alu_latch_flags};
            if (!rst) chk("alu_own", o_alu_own, o_busy);
            if (o_done && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product_hi", o_product_hi, e.prod[2*W-1:W]);
                    chk("product_lo", o_product_lo, e.prod[W-1:0]);
                    chk("latency", en_cnt - e.start_cnt, 2 * W + 1);
                    chk("flag_zero", f_zero, e.prod[W-1:0] == '0);
                    chk("flag_odd", f_odd, e.prod[0]);
                    chk("flag_carry", f_carry, 0);
                    last_prod = e.prod;
                end
            end else if (!rst) begin
                chk("product_hold", {o_product_hi, o_product_lo}, last_prod);
            end
            if (snap_vld && !snap_en && !snap_rst) chk("disabled_edge_hold", cur, snap);
            snap     = cur;
            snap_en  = clk_en;
            snap_rst = rst;
            snap_vld = 1'b1;
            prev_done = o_done;
        end
    end

    // Holds i_start until an enabled edge finds the block idle, then records the expectation.
    task automatic start_op(input logic [W-1:0] mm, input logic [W-1:0] qq);
        logic acc;
        exp_t e;
        int   n;
        i_multiplicand = mm;
        i_multiplier   = qq;
        i_start        = 1'b1;
        n = 0;
        forever begin
            acc = clk_en && !o_busy && !rst;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 300) begin
                chk("start_timeout", 1, 0);
                i_start = 1'b0;
                return;
            end
            #2;
        end
        e.prod      = {{W{1'b0}}, mm} * {{W{1'b0}}, qq};
        e.start_cnt = en_cnt;
        sb.push_back(e);
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int adds;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_product", {o_product_hi, o_product_lo}, 0);
        chk("rst_alu_op", o_alu_op, A_CHK);
        chk("rst_alu_latch", o_alu_latch_flags, 0);
        chk("rst_alu_a", o_alu_a, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        start_op(8'd13, 8'd11);   wait_idle();
        start_op(8'd255, 8'd255); wait_idle();
        start_op(8'd128, 8'd2);   wait_idle();
        start_op(8'd0, 8'h5A);    wait_idle();

        en_rand = 1'b1;
        start_op(8'd200, 8'd77);  wait_idle();

        // A second start mid-operation must be dropped.
        start_op(8'd57, 8'd93);
        repeat (5) @(posedge clk);
        #3;
        i_multiplicand = 8'd1;
        i_multiplier   = 8'd1;
        i_start        = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        i_start = 1'b0;
        wait_idle();

        // Back-to-back random operations, each start issued in the o_done cycle.
        for (int k = 0; k < 20; k++) begin
            start_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_idle();
        end

        // Reset during the ADD of bit 4.
        en_rand = 1'b0;
        @(posedge clk);
        #3;
        start_op(8'd99, 8'd201);
        adds = 0;
        for (int n = 0; n < 100 && adds < 5; n++) begin
            @(negedge clk);
            if (o_alu_latch_flags && o_alu_op == A_ADD) adds++;
        end
        chk("reached_add4", adds, 5);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_product", {o_product_hi, o_product_lo}, 0);
        sb.delete();
        last_prod = '0;
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_done", o_done, 0);
        #2;
        start_op(8'd13, 8'd11);
        wait_idle();
        en_rand = 1'b1;
        start_op(8'd255, 8'd1);
        wait_idle();

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
